muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Execute-stage sequencer for the shared multi-cycle multiplier and divider units, which use a level valid/done handshake.
- Accepts one MULT/MULTU/DIV/DIVU/MUL request from the execute stage and converts operands to magnitudes.
- Launches the correct unit and stalls the pipeline until the unit reports done.
- Applies the sign fixup and presents a one-cycle HI/LO or GPR write.
- Owns cancellation on flush and reset.

Parameters:
DATA_W, 32, operand width; products and quotient/remainder pairs are 2*DATA_W.
WDOG_CYCLES, 0, busy-cycle limit before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock; all state changes on posedge.
resetn  in  1  synchronous active-low reset.
req_valid  in  1  execute stage holds a mul/div instruction; held stable while stall=1.
req_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MUL (GPR dest); 5-7 ignored.
req_a, req_b  in  DATA_W  rs/rt values (dividend/divisor for DIV).
flush  in  1  exception/redirect kill of the in-flight request.
unit_a, unit_b  out  DATA_W  operand magnitudes to both units.
mul_valid, div_valid  out  1  launch level to the multiplier/divider.
mul_done, div_done  in  1  unit result ready.
mul_c, div_c  in  2*DATA_W  unsigned product; {remainder, quotient} for divide.
stall  out  1  freeze the front end and execute stage.
hi_we, lo_we  out  1  one-cycle HI/LO write strobes.
gpr_we  out  1  one-cycle GPR write for MUL.
res_hi, res_lo  out  DATA_W  registered result; res_lo is also the MUL GPR value.
wdog_err  out  1  sticky flag set by a watchdog abort.

Behaviour:
Reset (resetn=0 at posedge, any state):
- Go to IDLE.
- Clear all strobes, valids, res_hi, res_lo and wdog_err.
- Unit requests drop the same cycle.

States: IDLE, MBUSY, DBUSY, DONE.

IDLE:
- A valid op (0-4) with flush=0 latches op, signs and magnitudes.
- Magnitude is the two's complement of a negative signed operand. 0x8000_0000 stays 0x8000_0000 and is read as unsigned.
- Next state is MBUSY for ops 0/1/4 and DBUSY for ops 2/3.
- stall is combinational: 1 when req_valid && valid op && !flush.

MBUSY/DBUSY:
- Hold mul_valid/div_valid=1 and keep unit_a/unit_b constant. stall=1.
- On done: register the fixed-up result and go to DONE.
- Busy count starts at 1 in the first busy cycle.

DONE (exactly one cycle):
- stall=0.
- Ops 0-3: hi_we=lo_we=1.
- Op 4: gpr_we=1 only, with res_lo = low word; HI/LO untouched.
- Next state IDLE. The requester removes the retired instruction, so it is never reissued.

Fixup rules:
- MULT/MUL: negate the 64-bit product if the operand signs differ.
- DIV: quotient negated if the signs differ; remainder takes the dividend sign.
- Unsigned ops: pass-through.
- Latency with a unit of latency L: req to DONE = L+1 cycles.

flush:
- Any state: next state IDLE, valids drop next cycle, no write strobe.
- res_hi/res_lo unchanged.
- flush has priority over a simultaneous done.

Watchdog (WDOG_CYCLES>0):
- Busy count reaching WDOG_CYCLES without done: go to IDLE, set wdog_err, no write.

Other cases:
- done from the inactive unit is ignored.
- Ops 5-7 never stall and produce no write.
- res_hi/res_lo hold their value between operations.

Optional Feature:
MULDIV_DIVZERO_FAST_EN
- Defined: DIV/DIVU with req_b=0 skips the divider and goes IDLE to DONE directly, with res_hi=req_a and res_lo=all ones. stall=1 only in the IDLE cycle, so total 2 cycles.
- Undefined: divide by zero is launched to the divider like any other divide, and its result is written unmodified except for the sign fixup.

Test Plan:
- MULT a=0xFFFF_FFFD (-3), b=5, multiplier L=4: stall for 5 cycles; then DONE with hi_we=lo_we=1, res_hi=0xFFFF_FFFF, res_lo=0xFFFF_FFF1.
- DIV a=0xFFFF_FFF9 (-7), b=2: res_lo=0xFFFF_FFFD (-3), res_hi=0xFFFF_FFFF (-1). Repeat with DIVU 7/2: res_lo=3, res_hi=1.
- MUL a=0x0001_0000, b=0x0001_0000: gpr_we=1, res_lo=0, hi_we=lo_we=0. Then issue MULTU 0xFFFF_FFFF*0xFFFF_FFFF on the next cycle: res_hi=0xFFFF_FFFE, res_lo=1.
- Flush on the 2nd busy cycle of DIVU, including the same cycle as div_done:
  - next cycle IDLE, div_valid=0;
  - no strobes, prior res_hi/res_lo kept.
  Then resetn=0 mid-MBUSY: all outputs 0 on the next cycle.
- With the macro defined, DIVU a=7, b=0: div_valid stays 0; DONE on the 2nd cycle with res_hi=7, res_lo=0xFFFF_FFFF. Without the macro, the divider is launched.
- WDOG_CYCLES=8, mul_done tied 0: abort after 8 busy cycles, wdog_err=1, stall=0, no write.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle multiplier and divider.
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide-by-zero bypasses the divider.
module muldiv_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WDOG_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  input  logic                  flush,
  output logic [DATA_W-1:0]     unit_a,
  output logic [DATA_W-1:0]     unit_b,
  output logic                  mul_valid,
  output logic                  div_valid,
  input  logic                  mul_done,
  input  logic                  div_done,
  input  logic [2*DATA_W-1:0]   mul_c,
  input  logic [2*DATA_W-1:0]   div_c,
  output logic                  stall,
  output logic                  hi_we,
  output logic                  lo_we,
  output logic                  gpr_we,
  output logic [DATA_W-1:0]     res_hi,
  output logic [DATA_W-1:0]     res_lo,
  output logic                  wdog_err
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMul   = 3'd4;

`ifdef MULDIV_DIVZERO_FAST_EN
  localparam bit DivZeroFast = 1'b1;
`else
  localparam bit DivZeroFast = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StMBusy, StDBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [DATA_W-1:0]   mag_a_q, mag_a_d;
  logic [DATA_W-1:0]   mag_b_q, mag_b_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d;
  logic [DATA_W-1:0]   res_lo_q, res_lo_d;
  logic                wdog_err_q, wdog_err_d;

  logic                req_known;
  logic                req_signed;
  logic                req_is_div;
  logic                accept;
  logic                req_sign_a;
  logic                req_sign_b;
  logic                wdog_hit;
  logic [2*DATA_W-1:0] prod_fx;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo_fx;
  logic [DATA_W-1:0]   rem_fx;

  // Request decode
  assign req_known  = (req_op <= OpMul);
  assign req_signed = (req_op == OpMult) || (req_op == OpDiv) || (req_op == OpMul);
  assign req_is_div = (req_op == OpDiv) || (req_op == OpDivu);
  assign accept     = req_valid && req_known && !flush;
  assign req_sign_a = req_signed && req_a[DATA_W-1];
  assign req_sign_b = req_signed && req_b[DATA_W-1];

  // Sign bits are only ever set for signed ops, so unsigned ops pass straight through.
  assign prod_fx = (sign_a_q ^ sign_b_q) ? -mul_c : mul_c;
  assign quo     = div_c[DATA_W-1:0];
  assign rem     = div_c[2*DATA_W-1:DATA_W];
  assign quo_fx  = (sign_a_q ^ sign_b_q) ? -quo : quo;
  assign rem_fx  = sign_a_q ? -rem : rem;

  assign wdog_hit = (WDOG_CYCLES != 0) && (cnt_q >= WDOG_CYCLES);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      cnt_q      <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      cnt_q      <= cnt_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    cnt_d      = cnt_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    wdog_err_d = wdog_err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = req_op;
          sign_a_d = req_sign_a;
          sign_b_d = req_sign_b;
          // 0x8000_0000 negates to itself, which reads correctly as an unsigned magnitude.
          mag_a_d  = req_sign_a ? -req_a : req_a;
          mag_b_d  = req_sign_b ? -req_b : req_b;
          cnt_d    = 32'd1;
          if (req_is_div) begin
            state_d = StDBusy;
            if (DivZeroFast && (req_b == '0)) begin
              state_d  = StDone;
              res_hi_d = req_a;
              res_lo_d = '1;
            end
          end else begin
            state_d = StMBusy;
          end
        end
      end

      StMBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else if (mul_done) begin
          state_d  = StDone;
          res_lo_d = prod_fx[DATA_W-1:0];
          if (op_q != OpMul) begin
            res_hi_d = prod_fx[2*DATA_W-1:DATA_W];
          end
        end else if (wdog_hit) begin
          state_d    = StIdle;
          wdog_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StDBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else if (div_done) begin
          state_d  = StDone;
          res_hi_d = rem_fx;
          res_lo_d = quo_fx;
        end else if (wdog_hit) begin
          state_d    = StIdle;
          wdog_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset removes unit requests and strobes in the same cycle it is asserted.
  assign mul_valid = resetn && (state_q == StMBusy);
  assign div_valid = resetn && (state_q == StDBusy);
  assign stall     = resetn && ((state_q == StMBusy) || (state_q == StDBusy) ||
                                ((state_q == StIdle) && accept));
  assign hi_we     = resetn && !flush && (state_q == StDone) && (op_q != OpMul);
  assign lo_we     = resetn && !flush && (state_q == StDone) && (op_q != OpMul);
  assign gpr_we    = resetn && !flush && (state_q == StDone) && (op_q == OpMul);

  assign unit_a   = mag_a_q;
  assign unit_b   = mag_b_q;
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;
  assign wdog_err = wdog_err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with behavioural mul/div unit models.
// A second instance with WDOG_CYCLES=8 and a dead multiplier exercises the watchdog.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic [31:0] unit_a, unit_b;
  logic        mul_valid, div_valid;
  logic        mul_done, div_done;
  logic [63:0] mul_c, div_c;
  logic        stall, hi_we, lo_we, gpr_we;
  logic [31:0] res_hi, res_lo;
  logic        wdog_err;

  logic        w_req_valid;
  logic [2:0]  w_req_op;
  logic [31:0] w_req_a, w_req_b;
  logic [31:0] w_unit_a, w_unit_b;
  logic        w_mul_valid, w_div_valid;
  logic        w_stall, w_hi_we, w_lo_we, w_gpr_we;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_wdog_err;

  int          mul_cnt = 0;
  int          div_cnt = 0;
  int          mul_lat = 4;
  int          div_lat = 3;
  logic        inj_div_done = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.DATA_W(32), .WDOG_CYCLES(0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .mul_valid (mul_valid),
    .div_valid (div_valid),
    .mul_done  (mul_done),
    .div_done  (div_done),
    .mul_c     (mul_c),
    .div_c     (div_c),
    .stall     (stall),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .gpr_we    (gpr_we),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .wdog_err  (wdog_err)
  );

  muldiv_ctrl #(.DATA_W(32), .WDOG_CYCLES(8)) dut_wd (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (w_req_valid),
    .req_op    (w_req_op),
    .req_a     (w_req_a),
    .req_b     (w_req_b),
    .flush     (1'b0),
    .unit_a    (w_unit_a),
    .unit_b    (w_unit_b),
    .mul_valid (w_mul_valid),
    .div_valid (w_div_valid),
    .mul_done  (1'b0),
    .div_done  (1'b0),
    .mul_c     (64'd0),
    .div_c     (64'd0),
    .stall     (w_stall),
    .hi_we     (w_hi_we),
    .lo_we     (w_lo_we),
    .gpr_we    (w_gpr_we),
    .res_hi    (w_res_hi),
    .res_lo    (w_res_lo),
    .wdog_err  (w_wdog_err)
  );

  // Unit models: done rises on the lat-th cycle that valid has been held.
  always @(posedge clk) begin
    mul_cnt <= mul_valid ? mul_cnt + 1 : 0;
    div_cnt <= div_valid ? div_cnt + 1 : 0;
  end
  assign mul_done = mul_valid && (mul_cnt == mul_lat - 1);
  assign div_done = (div_valid && (div_cnt == div_lat - 1)) || inj_div_done;
  assign mul_c    = {32'd0, unit_a} * {32'd0, unit_b};
  assign div_c    = (unit_b == 32'd0) ? {unit_a, 32'hFFFF_FFFF}
                                      : {unit_a % unit_b, unit_a / unit_b};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and hold it until stall falls; returns in the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output logic [31:0] ua, output logic [31:0] ub,
                        output logic saw_div);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    n_stall   = 0;
    ua        = '0;
    ub        = '0;
    saw_div   = 1'b0;
    #1;
    while (stall && n_stall < 50) begin
      n_stall++;
      tick();
      if (n_stall == 1) begin
        ua = unit_a;
        ub = unit_b;
      end
      if (div_valid) saw_div = 1'b1;
    end
  endtask

  task automatic flush_case(input int lat, input string tag);
    div_lat   = lat;
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_a     = 32'd9;
    req_b     = 32'd4;
    tick();
    tick();
    check_eq({tag, "_busy2_dv"}, div_valid, 1);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq({tag, "_div_valid"}, div_valid, 0);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_we"}, {hi_we, lo_we, gpr_we}, 0);
    check_eq({tag, "_res"}, {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    check_eq({tag, "_we_later"}, {hi_we, lo_we, gpr_we}, 0);
    check_eq({tag, "_res_later"}, {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          ns;
    int          nb;
    logic [31:0] ua, ub;
    logic        sd;
    logic        we_seen;

    resetn      = 1'b0;
    req_valid   = 1'b0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    flush       = 1'b0;
    w_req_valid = 1'b0;
    w_req_op    = '0;
    w_req_a     = '0;
    w_req_b     = '0;
    tick();
    tick();
    check_eq("rst_outs", {stall, mul_valid, div_valid, hi_we, lo_we, gpr_we, wdog_err}, 0);
    check_eq("rst_res", {res_hi, res_lo}, 0);
    resetn = 1'b1;
    tick();

    // MULT -3 * 5, L=4
    mul_lat = 4;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, ns, ua, ub, sd);
    check_eq("mult_stall", ns, 5);
    check_eq("mult_mag", {ua, ub}, {32'd3, 32'd5});
    check_eq("mult_we", {hi_we, lo_we, gpr_we}, 3'b110);
    check_eq("mult_res", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();

    // DIV -7 / 2, L=3
    div_lat = 3;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, ns, ua, ub, sd);
    check_eq("div_stall", ns, 4);
    check_eq("div_mag", {ua, ub}, {32'd7, 32'd2});
    check_eq("div_we", {hi_we, lo_we, gpr_we}, 3'b110);
    check_eq("div_res", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();

    // DIVU 7 / 2
    run_op(3'd3, 32'd7, 32'd2, ns, ua, ub, sd);
    check_eq("divu_stall", ns, 4);
    check_eq("divu_res", {res_hi, res_lo}, {32'd1, 32'd3});
    tick();

    // MUL 0x10000 * 0x10000 -> GPR gets low word 0
    run_op(3'd4, 32'h0001_0000, 32'h0001_0000, ns, ua, ub, sd);
    check_eq("mul_stall", ns, 5);
    check_eq("mul_we", {hi_we, lo_we, gpr_we}, 3'b001);
    check_eq("mul_res_lo", res_lo, 0);
    tick();

    // MULTU max*max back to back, with a stray divider done that must be ignored
    inj_div_done = 1'b1;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, ua, ub, sd);
    inj_div_done = 1'b0;
    check_eq("multu_stall", ns, 5);
    check_eq("multu_we", {hi_we, lo_we, gpr_we}, 3'b110);
    check_eq("multu_res", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Reserved op never stalls or writes
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = 32'd1;
    req_b     = 32'd1;
    #1;
    check_eq("op5_stall", stall, 0);
    tick();
    check_eq("op5_outs", {hi_we, lo_we, gpr_we, mul_valid, div_valid}, 0);
    check_eq("op5_res", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    req_valid = 1'b0;
    tick();

    flush_case(4, "flush_nodone");
    flush_case(2, "flush_done");

    // Divide by zero
    div_lat = 3;
    run_op(3'd3, 32'd7, 32'd0, ns, ua, ub, sd);
`ifdef MULDIV_DIVZERO_FAST_EN
    check_eq("dz_stall", ns, 1);
    check_eq("dz_div_valid", sd, 0);
`else
    check_eq("dz_stall", ns, 4);
    check_eq("dz_div_valid", sd, 1);
`endif
    check_eq("dz_we", {hi_we, lo_we, gpr_we}, 3'b110);
    check_eq("dz_res", {res_hi, res_lo}, 64'h0000_0007_FFFF_FFFF);
    tick();

    // Reset in the middle of a multiply
    mul_lat   = 6;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd3;
    req_b     = 32'd3;
    tick();
    tick();
    check_eq("rstmid_busy", mul_valid, 1);
    resetn = 1'b0;
    #1;
    check_eq("rstmid_same_cycle", {mul_valid, stall}, 0);
    tick();
    req_valid = 1'b0;
    #1;
    check_eq("rstmid_outs", {stall, mul_valid, div_valid, hi_we, lo_we, gpr_we, wdog_err}, 0);
    check_eq("rstmid_res", {res_hi, res_lo}, 0);
    resetn = 1'b1;
    tick();

    // Watchdog instance: multiplier never answers
    w_req_valid = 1'b1;
    w_req_op    = 3'd0;
    w_req_a     = 32'd2;
    w_req_b     = 32'd3;
    #1;
    check_eq("wd_accept_stall", w_stall, 1);
    nb      = 0;
    we_seen = 1'b0;
    tick();
    while (w_mul_valid && nb < 50) begin
      nb++;
      if (w_hi_we || w_lo_we || w_gpr_we) we_seen = 1'b1;
      if (nb == 8) check_eq("wd_err_before", w_wdog_err, 0);
      tick();
    end
    w_req_valid = 1'b0;
    #1;
    check_eq("wd_busy_cycles", nb, 8);
    check_eq("wd_err", w_wdog_err, 1);
    check_eq("wd_stall", w_stall, 0);
    check_eq("wd_no_write", {we_seen, w_hi_we, w_lo_we, w_gpr_we}, 0);
    tick();
    check_eq("wd_err_sticky", w_wdog_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
